// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Registered outputs; never writes while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [IDX_WIDTH-1:0]          last_idx,
  output logic                          busy
);

  typedef enum logic {ARB, WRITE} state_t;

  state_t                 state, state_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic                   wr_d;
  logic                   busy_d;
  logic [DATA_WIDTH-1:0]  data_d;
  logic [IDX_WIDTH-1:0]   last_d;
  logic [IDX_WIDTH-1:0]   win;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   found;
  logic [DATA_WIDTH-1:0]  words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_WIDTH'((int'(last_idx) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = '0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    data_d  = fifo_w_data;
    last_d  = last_idx;
    unique case (state)
      ARB: begin
        if (found && !fifo_full) begin
          state_d = WRITE;
          gnt_d   = NUM_REQ'(1) << win;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          data_d  = words[win];
          last_d  = win;
        end
      end
      WRITE: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      gnt         <= '0;
      fifo_wr     <= 1'b0;
      fifo_w_data <= '0;
      last_idx    <= IDX_WIDTH'(NUM_REQ - 1);
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      gnt         <= gnt_d;
      fifo_wr     <= wr_d;
      fifo_w_data <= data_d;
      last_idx    <= last_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and random traffic against a round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic          fifo_full = 1'b0;
  logic [NR-1:0] gnt;
  logic          fifo_wr;
  logic [DW-1:0] fifo_w_data;
  logic [IW-1:0] last_idx;
  logic          busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data), .last_idx(last_idx), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic hs_on = 1'b0;

  for (genvar i = 0; i < NR; i++) begin : g_hs
    assert property (@(posedge clk) disable iff (!reset || !hs_on)
      (req[i] && !gnt[i]) |=> (req[i] || gnt[i]))
      else $error("FAIL handshake: req %0d dropped before grant", i);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic          rst;
    logic [NR-1:0] req;
    logic [31:0]   data;
    logic          full;
    logic [NR-1:0] gnt;
    logic          wr;
    logic [DW-1:0] wd;
    logic [IW-1:0] last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic [3:0] q,
      logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3,
      logic f, logic [3:0] g, logic w, logic [7:0] wd, logic [1:0] l);
    vec_t t;
    t.rst = r; t.req = q; t.data = {d3, d2, d1, d0}; t.full = f;
    t.gnt = g; t.wr = w; t.wd = wd; t.last = l;
    return t;
  endfunction

  // Producers, bench-side FIFO and reference model state
  logic [DW-1:0] pbuf [NR][64];
  int            ph [NR];
  int            pt [NR];
  int            wt [NR];
  logic [DW-1:0] fq[$];
  logic [NR-1:0] exp_gnt;
  logic          exp_wr;
  logic [DW-1:0] exp_data;
  int            exp_last;
  logic          last_wr;
  logic [DW-1:0] last_wd;

  task automatic push(int i, logic [DW-1:0] d);
    pbuf[i][pt[i] % 64] = d;
    pt[i]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i] = (pt[i] != ph[i]);
      req_data[i*DW +: DW] = req[i] ? pbuf[i][ph[i] % 64] : '0;
    end
    fifo_full = (fq.size() >= DEPTH);
  endtask

  function automatic int pick(logic [NR-1:0] r, int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_gnt = '0; exp_wr = 1'b0; exp_data = '0; exp_last = NR - 1;
  endtask

  // A grant is possible only if the previous cycle carried none.
  task automatic predict();
    int w;
    if (!reset) begin
      model_reset();
    end else if (!exp_wr && req != '0 && !fifo_full) begin
      w = pick(req, exp_last);
      exp_gnt = NR'(1) << w;
      exp_wr = 1'b1;
      exp_data = req_data[w*DW +: DW];
      exp_last = w;
    end else begin
      exp_gnt = '0;
      exp_wr = 1'b0;
    end
  endtask

  task automatic check_outs(string tag);
    cmp({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    cmp({tag, "_wr"}, 32'(fifo_wr), 32'(exp_wr));
    cmp({tag, "_data"}, 32'(fifo_w_data), 32'(exp_data));
    cmp({tag, "_last"}, 32'(last_idx), 32'(exp_last));
    cmp({tag, "_busy"}, 32'(busy), 32'(exp_wr));
  endtask

  task automatic post();
    last_wr = fifo_wr;
    last_wd = fifo_w_data;
    if (fifo_wr) begin
      fq.push_back(fifo_w_data);
      for (int i = 0; i < NR; i++) begin
        if (gnt[i]) wt[i] = 0;
        else if (req[i]) begin
          wt[i]++;
          cmp($sformatf("fair_%0d", i), 32'(wt[i] < NR), 32'd1);
        end
      end
    end
    for (int i = 0; i < NR; i++)
      if (gnt[i] && req[i]) ph[i]++;
  endtask

  task automatic tick();
    drive_inputs();
    predict();
    @(posedge clk);
    @(negedge clk);
    check_outs("m");
    post();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ph[i] = 0; pt[i] = 0; wt[i] = 0;
    end
    fq.delete();
    drive_inputs();
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_outs("rst");
    end
    reset = 1'b1;
  endtask

  initial begin
    int n, wrc, got;
    // reset
    tbl.push_back(v(0, 4'hF, 9, 14, 13, 6, 0, 4'h0, 0, 0, 3));
    tbl.push_back(v(0, 4'hF, 9, 14, 13, 6, 0, 4'h0, 0, 0, 3));
    // single requester 2: 5, 8, 12
    tbl.push_back(v(1, 4'b0100, 0, 0, 5, 0, 0, 4'b0100, 1, 5, 2));
    tbl.push_back(v(1, 4'b0100, 0, 0, 8, 0, 0, 4'b0000, 0, 5, 2));
    tbl.push_back(v(1, 4'b0100, 0, 0, 8, 0, 0, 4'b0100, 1, 8, 2));
    tbl.push_back(v(1, 4'b0100, 0, 0, 12, 0, 0, 4'b0000, 0, 8, 2));
    tbl.push_back(v(1, 4'b0100, 0, 0, 12, 0, 0, 4'b0100, 1, 12, 2));
    tbl.push_back(v(1, 4'b0000, 0, 0, 12, 0, 0, 4'b0000, 0, 12, 2));
    // all four: order 0,1,2,3,0
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0001, 1, 9, 0));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0000, 0, 9, 0));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0010, 1, 14, 1));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0000, 0, 14, 1));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0100, 1, 13, 2));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0000, 0, 13, 2));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b1000, 1, 6, 3));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0000, 0, 6, 3));
    tbl.push_back(v(1, 4'hF, 9, 14, 13, 6, 0, 4'b0001, 1, 9, 0));
    tbl.push_back(v(1, 4'h0, 9, 14, 13, 6, 0, 4'b0000, 0, 9, 0));
    // wrap 0 <-> 3, with a full cycle blocking arbitration
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b0001, 1, 8'h11, 0));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b0000, 0, 8'h11, 0));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 1, 4'b0000, 0, 8'h11, 0));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b1000, 1, 8'h33, 3));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b0000, 0, 8'h33, 3));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b0001, 1, 8'h11, 0));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b0000, 0, 8'h11, 0));
    tbl.push_back(v(1, 4'b1001, 8'h11, 0, 0, 8'h33, 0, 4'b1000, 1, 8'h33, 3));
    tbl.push_back(v(1, 4'h0, 8'h11, 0, 0, 8'h33, 0, 4'b0000, 0, 8'h33, 3));

    @(negedge clk);
    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst;
      req = tbl[r].req;
      req_data = tbl[r].data;
      fifo_full = tbl[r].full;
      @(posedge clk);
      @(negedge clk);
      cmp($sformatf("t%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      cmp($sformatf("t%0d_wr", r), 32'(fifo_wr), 32'(tbl[r].wr));
      cmp($sformatf("t%0d_data", r), 32'(fifo_w_data), 32'(tbl[r].wd));
      cmp($sformatf("t%0d_last", r), 32'(last_idx), 32'(tbl[r].last));
      cmp($sformatf("t%0d_busy", r), 32'(busy), 32'(tbl[r].wr));
    end

    // full FIFO holds off requester 1 until one read
    do_reset();
    hs_on = 1'b1;
    for (int k = 0; k < DEPTH; k++) push(0, 8'(8'h40 + k));
    n = 0;
    while (fq.size() < DEPTH && n < 40) begin
      tick();
      n++;
    end
    cmp("full_fill", 32'(fq.size()), DEPTH);
    push(1, 8'd7);
    wrc = 0;
    repeat (6) begin
      tick();
      if (last_wr) wrc++;
    end
    cmp("full_no_wr", 32'(wrc), 0);
    void'(fq.pop_front());
    got = 0;
    repeat (2) begin
      tick();
      if (last_wr && last_wd == 8'd7) got++;
    end
    cmp("full_freed", 32'(got), 1);

    // reset landing in the write cycle
    do_reset();
    push(2, 8'h5A);
    drive_inputs();
    @(posedge clk);
    #1;
    cmp("rw_wr_hi", 32'(fifo_wr), 1);
    cmp("rw_gnt_hi", 32'(gnt), 32'h4);
    reset = 1'b0;
    #1;
    cmp("rw_wr_drop", 32'(fifo_wr), 0);
    cmp("rw_gnt_drop", 32'(gnt), 0);
    cmp("rw_busy_drop", 32'(busy), 0);
    cmp("rw_last_rst", 32'(last_idx), 3);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    wrc = 0;
    repeat (6) begin
      tick();
      if (last_wr) begin
        wrc++;
        cmp("rw_data", 32'(last_wd), 32'h5A);
      end
    end
    cmp("rw_once", 32'(wrc), 1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++)
        if (pt[i] == ph[i] && $urandom_range(3) == 0)
          push(i, 8'($urandom));
      if (fq.size() > 0 && $urandom_range(c < 400 ? 5 : 1) == 0)
        void'(fq.pop_front());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
